// File: rtl/io_port_controller.sv
`default_nettype none
// ============================================================================
//  Module      : io_port_controller
//  Description : Memory-mapped I/O port for the single-cycle MIPS core.
//                16-byte window with OUT / IN / EDGE / COUNT registers,
//                two-flop synchronised and debounced 8-bit switch input,
//                sticky rising-edge flags and a saturating event counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_port_controller #(
   parameter logic [31:0] BASE_ADDRESS    = 32'h1001_0100,
   parameter int          DEBOUNCE_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [7:0]  PortIn,
   output logic        Hit,
   output logic [31:0] ReadData,
   output logic [31:0] PortOut
);

   localparam int            CW        = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] C_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] C_OFF_OUT   = 2'd0;
   localparam logic [1:0] C_OFF_IN    = 2'd1;
   localparam logic [1:0] C_OFF_EDGE  = 2'd2;
   localparam logic [1:0] C_OFF_COUNT = 2'd3;

   logic [7:0]  r_sync1;
   logic [7:0]  r_sync2;
   logic [7:0]  w_deb;
   logic [7:0]  w_rise;
   logic [7:0]  r_flags;
   logic [31:0] r_count;
   logic [31:0] r_port_out;
   logic [31:0] w_rd_data;
   logic [1:0]  w_off;
   logic        w_wr;
   logic [7:0]  w_clr;
   logic        w_unused_addr;

   // Byte lane bits are irrelevant for word-wide registers.
   assign w_unused_addr = &{1'b0, Address[1:0]};

   assign Hit     = (Address[31:4] == BASE_ADDRESS[31:4]);
   assign w_off   = Address[3:2];
   assign w_wr    = Hit & MemWrite;
   assign w_clr   = (w_wr && (w_off == C_OFF_EDGE)) ? WriteData[7:0] : 8'h00;
   assign PortOut = r_port_out;

   // Two-flop synchroniser for the asynchronous switch inputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 8'h00;
         r_sync2 <= 8'h00;
      end else begin
         r_sync1 <= PortIn;
         r_sync2 <= r_sync1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_bit
         logic [CW-1:0] r_cnt;
         logic          r_deb;
         logic          w_diff;
         logic          w_toggle;

         assign w_diff   = r_sync2[gi] ^ r_deb;
         assign w_toggle = w_diff && (r_cnt == C_CNT_MAX);

         // Debouncer: any match restarts the stability count; the output
         // only follows after DEBOUNCE_CYCLES consecutive mismatches.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_cnt <= '0;
               r_deb <= 1'b0;
            end else if (!w_diff) begin
               r_cnt <= '0;
            end else if (w_toggle) begin
               r_deb <= ~r_deb;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end

         assign w_deb[gi]  = r_deb;
         assign w_rise[gi] = w_toggle & ~r_deb;
      end
   endgenerate

   // OUT register: store takes effect on the edge ending the instruction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_port_out <= 32'h0;
      end else if (w_wr && (w_off == C_OFF_OUT)) begin
         r_port_out <= WriteData;
      end
   end

   // Sticky flags: a new rising edge overrides a simultaneous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_flags <= 8'h00;
      end else begin
         r_flags <= (r_flags & ~w_clr) | w_rise;
      end
   end

   // Event counter: one per cycle with any rise, saturating; a store clears
   // it and wins over a coincident increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= 32'h0;
      end else if (w_wr && (w_off == C_OFF_COUNT)) begin
         r_count <= 32'h0;
      end else if ((|w_rise) && (r_count != 32'hFFFF_FFFF)) begin
         r_count <= r_count + 32'd1;
      end
   end

   // Combinational load path, zero when not selected.
   always_comb begin
      w_rd_data = 32'h0;
      if (Hit && MemRead) begin
         case (w_off)
            C_OFF_OUT:   w_rd_data = r_port_out;
            C_OFF_IN:    w_rd_data = {24'h0, w_deb};
            C_OFF_EDGE:  w_rd_data = {24'h0, r_flags};
            C_OFF_COUNT: w_rd_data = r_count;
            default:     w_rd_data = 32'h0;
         endcase
      end
   end

   assign ReadData = w_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_io_port_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_port_controller
//  Description : Self-checking bench for io_port_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_port_controller;

   localparam logic [31:0] C_BASE = 32'h1001_0100;
   localparam int          C_DEB  = 16;

   logic        clk;
   logic        reset;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [7:0]  PortIn;
   logic        Hit;
   logic [31:0] ReadData;
   logic [31:0] PortOut;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];

   typedef struct {
      bit          wr;
      logic [1:0]  off;
      logic [31:0] wdata;
      logic [1:0]  rd_off;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[6];

   io_port_controller #(
      .BASE_ADDRESS    (C_BASE),
      .DEBOUNCE_CYCLES (C_DEB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .Address   (Address),
      .WriteData (WriteData),
      .MemWrite  (MemWrite),
      .MemRead   (MemRead),
      .PortIn    (PortIn),
      .Hit       (Hit),
      .ReadData  (ReadData),
      .PortOut   (PortOut)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Load: expectation queued when the load is driven, compared on output.
   task automatic rd(input logic [1:0] off, input logic [31:0] exp, input string name);
      exp_t e;
      Address  = C_BASE + {28'h0, off, 2'b00};
      MemRead  = 1'b1;
      MemWrite = 1'b0;
      sb.push_back('{name, exp});
      #1;
      e = sb.pop_front();
      chk(e.name, ReadData, e.val);
      MemRead = 1'b0;
   endtask

   task automatic wr(input logic [1:0] off, input logic [31:0] data);
      Address   = C_BASE + {28'h0, off, 2'b00};
      WriteData = data;
      MemWrite  = 1'b1;
      MemRead   = 1'b0;
      tick(1);
      MemWrite  = 1'b0;
   endtask

   initial begin
      reset = 1'b1; Address = 32'h0; WriteData = 32'h0;
      MemWrite = 1'b0; MemRead = 1'b0; PortIn = 8'h00;

      vecs[0] = '{1'b1, 2'd0, 32'hA5A5_0F0F, 2'd0, 32'hA5A5_0F0F, "out_store"};
      vecs[1] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 2'd1, 32'h0000_0000, "in_readonly"};
      vecs[2] = '{1'b0, 2'd0, 32'h0,         2'd0, 32'hA5A5_0F0F, "out_hold"};
      vecs[3] = '{1'b1, 2'd2, 32'h0000_00FF, 2'd2, 32'h0000_0000, "edge_clr_empty"};
      vecs[4] = '{1'b1, 2'd3, 32'h0000_1234, 2'd3, 32'h0000_0000, "count_clr"};
      vecs[5] = '{1'b1, 2'd0, 32'h1234_5678, 2'd0, 32'h1234_5678, "out_store2"};

      tick(2);
      reset = 1'b0;
      tick(1);

      // Reset state
      chk("rst_portout", PortOut, 32'h0);
      rd(2'd1, 32'h0, "rst_in");
      rd(2'd2, 32'h0, "rst_edge");
      rd(2'd3, 32'h0, "rst_count");

      // Table-driven register access
      for (int i = 0; i < 6; i++) begin
         if (vecs[i].wr) begin
            wr(vecs[i].off, vecs[i].wdata);
            if (vecs[i].off == 2'd0) chk({vecs[i].name, "_port"}, PortOut, vecs[i].wdata);
         end
         rd(vecs[i].rd_off, vecs[i].exp, vecs[i].name);
         Address = C_BASE;
         #1;
         chk({vecs[i].name, "_hit"}, {31'h0, Hit}, 32'h1);
      end

      // Asynchronous reset mid-cycle
      tick(1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_portout", PortOut, 32'h0);
      rd(2'd0, 32'h0, "arst_out");
      rd(2'd1, 32'h0, "arst_in");
      Address = 32'h1001_0000;
      MemRead = 1'b1;
      #1;
      chk("arst_nohit", {31'h0, Hit}, 32'h0);
      chk("nohit_rd", ReadData, 32'h0);
      MemRead = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Debounce of a held step on bit 0
      PortIn = 8'h01;
      for (int e = 1; e <= 17; e++) begin
         tick(1);
         rd(2'd1, 32'h0, "deb_in_low");
      end
      tick(1);
      rd(2'd1, 32'h1, "deb_in_e18");
      rd(2'd2, 32'h1, "deb_edge_e18");
      rd(2'd3, 32'h1, "deb_count_e18");

      // Short glitch on bit 1 is filtered
      PortIn = 8'h03;
      tick(10);
      PortIn = 8'h01;
      for (int e = 0; e < 30; e++) begin
         tick(1);
         rd(2'd1, 32'h1, "glitch_in");
      end
      rd(2'd2, 32'h1, "glitch_edge");
      rd(2'd3, 32'h1, "glitch_count");

      // Flag clear racing a new rise on bit 1
      PortIn = 8'h03;
      tick(17);
      wr(2'd2, 32'h3);
      rd(2'd2, 32'h2, "race_edge");
      rd(2'd3, 32'h2, "race_count");

      // Falling edges leave flags and COUNT alone
      PortIn = 8'h00;
      tick(20);
      rd(2'd1, 32'h0, "fall_in");
      rd(2'd2, 32'h2, "fall_edge");
      rd(2'd3, 32'h2, "fall_count");

      // Two simultaneous rises count once
      PortIn = 8'h0C;
      tick(18);
      rd(2'd2, 32'hE, "dual_edge");
      rd(2'd3, 32'h3, "dual_count");

      // COUNT clear racing an increment
      PortIn = 8'h0D;
      tick(17);
      wr(2'd3, 32'hDEAD_BEEF);
      rd(2'd3, 32'h0, "cnt_race");
      rd(2'd2, 32'hF, "cnt_race_edge");

      // Saturation via backdoor preload
      force dut.r_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_count;
      rd(2'd3, 32'hFFFF_FFFF, "sat_preload");
      PortIn = 8'h1D;
      tick(18);
      rd(2'd1, 32'h1D, "sat_in");
      rd(2'd3, 32'hFFFF_FFFF, "sat_count");

      // Reset in the middle of a debounce
      PortIn = 8'h3D;
      tick(8);
      #2;
      reset = 1'b1;
      #1;
      rd(2'd1, 32'h0, "mid_rst_in");
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int e = 1; e <= 17; e++) begin
         tick(1);
         rd(2'd1, 32'h0, "mid_rst_low");
      end
      tick(1);
      rd(2'd1, 32'h3D, "mid_rst_in_e18");
      rd(2'd2, 32'h3D, "mid_rst_edge");
      rd(2'd3, 32'h1, "mid_rst_count");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
